instr_encoder_16ba: RTL and testbench

//  Packs MAS16bA instruction fields (opcode, rd, ra, rb or c) into 16-bit words and writes them to instruction memory.

---
 rtl/mas16ba_pkg.sv | 57 +++++
 rtl/instr_encoder_16ba.sv | 163 ++++++++++++++++
 tb/tb_instr_encoder_16ba.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mas16ba_pkg.sv
// mas16ba_pkg
//   Shared definitions for the MAS16bA instruction set: opcode constants
//   (also used by the decoder), instruction width, field bit positions,
//   encoder state encodings and the imm/reg operand-form classifier.
package mas16ba_pkg;

  localparam int INSTR_W = 16;

  // Field bit positions inside a 16-bit instruction word
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RA_MSB  = 9;
  localparam int RA_LSB  = 8;
  localparam int OPB_MSB = 7;
  localparam int OPB_LSB = 0;

  // Opcode map
  localparam logic [3:0] OP_ADC  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SBB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_SHF  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_ADI  = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_CMP  = 4'hC;
  localparam logic [3:0] OP_BR   = 4'hD;
  localparam logic [3:0] OP_CALL = 4'hE;
  localparam logic [3:0] OP_JMP  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } enc_state_t;

  // True when the low byte carries an 8-bit immediate; this is the same
  // set the decoder uses to select its B operand from the immediate.
  function automatic logic is_imm_form(input logic [3:0] opcode);
    logic imm;
    imm = 1'b0;
    case (opcode)
      OP_ADC, OP_LDI, OP_ADI, OP_LD, OP_BR, OP_CALL, OP_JMP: imm = 1'b1;
      OP_ADD, OP_SUB, OP_SBB, OP_AND, OP_OR, OP_XOR, OP_SHF,
      OP_ST, OP_CMP:                                          imm = 1'b0;
      default:                                                imm = 1'b0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/instr_encoder_16ba.sv
// instr_encoder_16ba
//   Packs MAS16bA instruction fields into 16-bit words and writes them to
//   consecutive instruction-memory addresses starting at BASE_ADDR.
//   Used for program load and BIST.
//
// Optional feature macro: ENC_CHECKSUM_EN (adds the checksum output).
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   start                    begin a load at BASE_ADDR (ignored while loading)
//   in_valid / in_ready      field-set handshake; in_ready while loading
//   in_opcode,in_rd,in_ra    instruction fields
//   in_rb / in_c             reg-form operand B / imm-form immediate
//   in_last                  final instruction of the program
//   imem_wen/addr/wdata      registered memory write, one cycle after accept
//   word_count               words written since start
//   busy / done              state is LOAD / DONE
//   overflow                 sticky: memory filled before in_last
//   checksum                 XOR of written words (ENC_CHECKSUM_EN only)
//   dvdd, dgnd               supply/ground pins, no logic
module instr_encoder_16ba
  import mas16ba_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_opcode,
  input  logic [1:0]           in_rd,
  input  logic [1:0]           in_ra,
  input  logic [1:0]           in_rb,
  input  logic [7:0]           in_c,
  input  logic                 in_last,
  output logic                 imem_wen,
  output logic [ADDR_W-1:0]    imem_addr,
  output logic [INSTR_W-1:0]   imem_wdata,
  output logic [ADDR_W:0]      word_count,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
`ifdef ENC_CHECKSUM_EN
  output logic [INSTR_W-1:0]   checksum,
`endif
  inout  wire                  dvdd,
  inout  wire                  dgnd
);

  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  enc_state_t            r_state;
  enc_state_t            w_state_next;
  logic [ADDR_W-1:0]     r_ptr;
  logic                  r_wen;
  logic [ADDR_W-1:0]     r_addr;
  logic [INSTR_W-1:0]    r_wdata;
  logic [ADDR_W:0]       r_count;
  logic                  r_overflow;
  logic                  w_accept;
  logic                  w_start_ok;
  logic                  w_at_end;
  logic [INSTR_W-1:0]    w_word;
  logic [7:0]            w_opb;

  // Supply pins carry no logic; folded here so they are visibly consumed.
  wire w_unused_supply = dvdd ^ dgnd;

  assign w_accept   = in_valid && (r_state == ST_LOAD);
  assign w_start_ok = start && (r_state != ST_LOAD);
  assign w_at_end   = (r_ptr == PTR_LAST);

  // Operand B byte: immediate, or register id zero-extended to 8 bits.
  assign w_opb = is_imm_form(in_opcode) ? in_c : {6'b0, in_rb};

  always_comb begin
    w_word                   = '0;
    w_word[OP_MSB:OP_LSB]    = in_opcode;
    w_word[RD_MSB:RD_LSB]    = in_rd;
    w_word[RA_MSB:RA_LSB]    = in_ra;
    w_word[OPB_MSB:OPB_LSB]  = w_opb;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_LOAD;
      ST_LOAD: if (w_accept && (in_last || w_at_end)) w_state_next = ST_DONE;
      ST_DONE: if (start) w_state_next = ST_LOAD;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath: write port, pointer, counters. start and accept are mutually
  // exclusive because accept needs LOAD and start is only honoured outside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_ptr      <= ADDR_W'(BASE_ADDR);
    end else begin
      r_wen <= w_accept;
      if (w_start_ok) begin
        r_ptr      <= ADDR_W'(BASE_ADDR);
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else if (w_accept) begin
        r_addr  <= r_ptr;
        r_wdata <= w_word;
        r_count <= r_count + (ADDR_W+1)'(1);
        // Pointer parks at the last address; the FSM leaves LOAD there.
        if (!w_at_end) begin
          r_ptr <= r_ptr + ADDR_W'(1);
        end
        if (w_at_end && !in_last) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

`ifdef ENC_CHECKSUM_EN
  logic [INSTR_W-1:0] r_checksum;

  // Updated on the accept edge, i.e. the same edge that raises imem_wen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_checksum <= '0;
    end else if (w_start_ok) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum ^ w_word;
    end
  end

  assign checksum = r_checksum;
`endif

  assign in_ready   = (r_state == ST_LOAD);
  assign busy       = (r_state == ST_LOAD);
  assign done       = (r_state == ST_DONE);
  assign imem_wen   = r_wen;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign word_count = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_instr_encoder_16ba.sv
// tb_instr_encoder_16ba
//   Directed bench for instr_encoder_16ba with a 4-word memory (ADDR_W=2)
//   so the full-memory cases are reachable in a few cycles.
//   Define ENC_CHECKSUM_EN to also exercise the checksum output.
module tb_instr_encoder_16ba;

  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_opcode;
  logic [1:0]        in_rd;
  logic [1:0]        in_ra;
  logic [1:0]        in_rb;
  logic [7:0]        in_c;
  logic              in_last;
  logic              imem_wen;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic [ADDR_W:0]   word_count;
  logic              busy;
  logic              done;
  logic              overflow;
`ifdef ENC_CHECKSUM_EN
  logic [15:0]       checksum;
`endif
  wire               dvdd;
  wire               dgnd;

  assign dvdd = 1'b1;
  assign dgnd = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  instr_encoder_16ba #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_ra      (in_ra),
    .in_rb      (in_rb),
    .in_c       (in_c),
    .in_last    (in_last),
    .imem_wen   (imem_wen),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
`ifdef ENC_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .dvdd       (dvdd),
    .dgnd       (dgnd)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Present one field set for a single edge; in_valid is left high so
  // back-to-back pushes stream without gaps.
  task automatic push(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                      input logic [1:0] rb, input logic [7:0] c, input logic last);
    in_valid  = 1'b1;
    in_opcode = op;
    in_rd     = rd;
    in_ra     = ra;
    in_rb     = rb;
    in_c      = c;
    in_last   = last;
    step();
    $display("push op=%h rd=%0d ra=%0d rb=%0d c=%h last=%0d -> wen=%0d addr=%0d wdata=%h",
             op, rd, ra, rb, c, last, imem_wen, imem_addr, imem_wdata);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_opcode = '0; in_rd = '0; in_ra = '0; in_rb = '0; in_c = '0; in_last = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_wen",   32'(imem_wen),   32'd0);
    chk("rst_addr",  32'(imem_addr),  32'd0);
    chk("rst_wdata", 32'(imem_wdata), 32'd0);
    chk("rst_count", 32'(word_count), 32'd0);
    chk("rst_done",  32'(done),       32'd0);
    chk("rst_ovf",   32'(overflow),   32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    rst = 1'b0;

    // Valid while IDLE is not accepted
    in_valid = 1'b1;
    step();
    chk("idle_ready", 32'(in_ready), 32'd0);
    chk("idle_nowen", 32'(imem_wen), 32'd0);
    in_valid = 1'b0;

    // 1: single reg-form ADD, last
    pulse_start();
    chk("t1_busy",  32'(busy),     32'd1);
    chk("t1_ready", 32'(in_ready), 32'd1);
    push(4'h1, 2'd1, 2'd2, 2'd3, 8'hAA, 1'b1);
    in_valid = 1'b0;
    chk("t1_wen",   32'(imem_wen),   32'd1);
    chk("t1_addr",  32'(imem_addr),  32'd0);
    chk("t1_wdata", 32'(imem_wdata), 32'h1603);
    chk("t1_done",  32'(done),       32'd1);
    chk("t1_count", 32'(word_count), 32'd1);
    step();
    chk("t1_wen_low", 32'(imem_wen), 32'd0);
    chk("t1_hold",    32'(done),     32'd1);

    // 2: imm ADC then JMP, streamed back to back
    pulse_start();
    chk("t2_count_clr", 32'(word_count), 32'd0);
    push(4'h0, 2'd0, 2'd1, 2'd3, 8'h5A, 1'b0);
    chk("t2_wen0",   32'(imem_wen),   32'd1);
    chk("t2_addr0",  32'(imem_addr),  32'd0);
    chk("t2_wdata0", 32'(imem_wdata), 32'h015A);
    push(4'hF, 2'd0, 2'd0, 2'd3, 8'h10, 1'b1);
    in_valid = 1'b0;
    chk("t2_wen1",   32'(imem_wen),   32'd1);
    chk("t2_addr1",  32'(imem_addr),  32'd1);
    chk("t2_wdata1", 32'(imem_wdata), 32'hF010);
    chk("t2_done",   32'(done),       32'd1);
    chk("t2_count",  32'(word_count), 32'd2);
`ifdef ENC_CHECKSUM_EN
    chk("t2_cksum",  32'(checksum),   32'hF14A);
`endif
    step();

    // 3: reg form ignores in_c
    pulse_start();
    push(4'h4, 2'd3, 2'd0, 2'd2, 8'hFF, 1'b1);
    in_valid = 1'b0;
    chk("t3_wdata", 32'(imem_wdata), 32'h4C02);
    step();

    // 4: fill memory without last -> overflow
    pulse_start();
    chk("t4_ovf_pre", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      push(4'h1, 2'd0, 2'd0, 2'(i), 8'h00, 1'b0);
      chk("t4_wen",   32'(imem_wen),   32'd1);
      chk("t4_addr",  32'(imem_addr),  32'(i));
      chk("t4_wdata", 32'(imem_wdata), 32'h1000 | 32'(i));
    end
    in_valid = 1'b0;
    chk("t4_ovf",   32'(overflow),   32'd1);
    chk("t4_done",  32'(done),       32'd1);
    chk("t4_ready", 32'(in_ready),   32'd0);
    chk("t4_count", 32'(word_count), 32'd4);
    step();
    chk("t4_nowen",   32'(imem_wen), 32'd0);
    chk("t4_sticky",  32'(overflow), 32'd1);
    pulse_start();
    chk("t4_ovf_clr", 32'(overflow), 32'd0);
    chk("t4_busy",    32'(busy),     32'd1);

    // 4b: last on the final address -> DONE without overflow; start in LOAD ignored
    push(4'h2, 2'd1, 2'd1, 2'd1, 8'h00, 1'b0);
    in_valid = 1'b0;
    pulse_start();
    for (int i = 1; i < 4; i++) begin
      push(4'h2, 2'd1, 2'd1, 2'd1, 8'h00, (i == 3));
      chk("t4b_addr", 32'(imem_addr), 32'(i));
    end
    in_valid = 1'b0;
    chk("t4b_done", 32'(done),     32'd1);
    chk("t4b_ovf",  32'(overflow), 32'd0);
    step();

    // 6: checksum over 1603 and 015A
    pulse_start();
`ifdef ENC_CHECKSUM_EN
    chk("t6_cksum_clr", 32'(checksum), 32'd0);
`endif
    push(4'h1, 2'd1, 2'd2, 2'd3, 8'h00, 1'b0);
    push(4'h0, 2'd0, 2'd1, 2'd0, 8'h5A, 1'b1);
    in_valid = 1'b0;
    chk("t6_wdata", 32'(imem_wdata), 32'h015A);
`ifdef ENC_CHECKSUM_EN
    chk("t6_cksum", 32'(checksum), 32'h1759);
    step();
    chk("t6_cksum_hold", 32'(checksum), 32'h1759);
`endif
    step();

    // 5: reset the cycle after an accept drops the write
    pulse_start();
    push(4'h3, 2'd2, 2'd2, 2'd2, 8'h00, 1'b0);
    in_valid = 1'b0;
    chk("t5_wen_pre", 32'(imem_wen), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_wen",   32'(imem_wen),   32'd0);
    chk("t5_busy",  32'(busy),       32'd0);
    chk("t5_count", 32'(word_count), 32'd0);
    chk("t5_done",  32'(done),       32'd0);
    pulse_start();
    push(4'h1, 2'd0, 2'd0, 2'd1, 8'h00, 1'b1);
    in_valid = 1'b0;
    chk("t5_addr",  32'(imem_addr),  32'd0);
    chk("t5_wdata", 32'(imem_wdata), 32'h1001);
    chk("t5_cnt1",  32'(word_count), 32'd1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
